// File: rtl/icache_fetch.sv
// Instruction-fetch stage: direct-mapped one-word-per-line I-cache in front of the memory
// controller's IF port, delivering {pc, inst} to the decoder under a valid/stall handshake.
//
// state    | meaning
// S_LOOKUP | tag compare on pc; hit delivers, miss raises a request
// S_REQ    | request held until the controller signals it has latched it
// S_WAIT   | waiting for the fill whose address equals pc
module icache_fetch #(
  parameter int unsigned IDX_W  = 6,
  parameter logic [31:0] RST_PC = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clr_in,
  input  logic [31:0] redirect_pc,
  input  logic        mc_to_if_valid,
  input  logic        mc_to_if_ready,
  input  logic [31:0] mc_to_if_inst,
  input  logic [31:0] mc_to_if_addr,
  output logic        if_to_mc_ready,
  output logic [31:0] if_to_mc_PC,
  input  logic        dec_stall,
  output logic        if_to_dec_valid,
  output logic [31:0] if_to_dec_inst,
  output logic [31:0] if_to_dec_pc
);
  localparam int unsigned LINES = 2**IDX_W;
  localparam int unsigned TAG_W = 30 - IDX_W;

  typedef enum logic [1:0] {S_LOOKUP, S_REQ, S_WAIT} state_e;

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic              mc_req_q, mc_req_d;
  logic [31:0]       mc_pc_q, mc_pc_d;
  logic              dec_valid_q, dec_valid_d;
  logic [31:0]       dec_inst_q, dec_inst_d;
  logic [31:0]       dec_pc_q, dec_pc_d;

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [31:0]       data_q [LINES];

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              hit;
  logic              stalled;
  logic              fill_match;
  logic              fill_we;

  assign idx        = pc_q[IDX_W+1:2];
  assign tag        = pc_q[31:IDX_W+2];
  assign hit        = valid_q[idx] && (tag_q[idx] == tag);
  assign stalled    = dec_valid_q && dec_stall;
  assign fill_match = mc_to_if_ready && (mc_to_if_addr == pc_q);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    mc_req_d    = mc_req_q;
    mc_pc_d     = mc_pc_q;
    dec_valid_d = dec_valid_q;
    dec_inst_d  = dec_inst_q;
    dec_pc_d    = dec_pc_q;
    fill_we     = 1'b0;
    if (clr_in) begin
      pc_d        = redirect_pc & ~32'h3;
      dec_valid_d = 1'b0;
      mc_req_d    = 1'b0;
      state_d     = S_LOOKUP;
    end else begin
      case (state_q)
        S_LOOKUP: begin
          if (!stalled) begin
            if (hit) begin
              dec_valid_d = 1'b1;
              dec_inst_d  = data_q[idx];
              dec_pc_d    = pc_q;
              pc_d        = pc_q + 32'd4;
            end else begin
              dec_valid_d = 1'b0;
              mc_req_d    = 1'b1;
              mc_pc_d     = pc_q;
              state_d     = S_REQ;
            end
          end
        end
        S_REQ: begin
          if (mc_to_if_valid) begin
            mc_req_d = 1'b0;
            state_d  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (fill_match) begin
            fill_we = 1'b1;
            state_d = S_LOOKUP;
            // a fill landing under a stall only updates the line; a later hit delivers it
            if (!stalled) begin
              dec_valid_d = 1'b1;
              dec_inst_d  = mc_to_if_inst;
              dec_pc_d    = pc_q;
              pc_d        = pc_q + 32'd4;
            end
          end
        end
        default: state_d = S_LOOKUP;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q     <= S_LOOKUP;
      pc_q        <= RST_PC;
      mc_req_q    <= 1'b0;
      mc_pc_q     <= 32'h0;
      dec_valid_q <= 1'b0;
      dec_inst_q  <= 32'h0;
      dec_pc_q    <= 32'h0;
      valid_q     <= '0;
    end else if (rdy_in) begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      mc_req_q    <= mc_req_d;
      mc_pc_q     <= mc_pc_d;
      dec_valid_q <= dec_valid_d;
      dec_inst_q  <= dec_inst_d;
      dec_pc_q    <= dec_pc_d;
      if (fill_we) valid_q[idx] <= 1'b1;
    end
  end

  // tag/data storage needs no reset: lines are qualified by valid_q
  always_ff @(posedge clk_in) begin
    if (rst_in && rdy_in && fill_we) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= mc_to_if_inst;
    end
  end

  assign if_to_mc_ready  = mc_req_q;
  assign if_to_mc_PC     = mc_pc_q;
  assign if_to_dec_valid = dec_valid_q;
  assign if_to_dec_inst  = dec_inst_q;
  assign if_to_dec_pc    = dec_pc_q;

endmodule

// File: tb/tb_icache_fetch.sv
// Scoreboard bench for icache_fetch: expected {pc, inst} stream per redirect segment, a
// memory-controller model with random latency and stray pulses, and a reference cache map.
module tb_icache_fetch;
  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        clr_in = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        mc_to_if_valid = 1'b0;
  logic        mc_to_if_ready = 1'b0;
  logic [31:0] mc_to_if_inst = 32'h0;
  logic [31:0] mc_to_if_addr = 32'h0;
  logic        if_to_mc_ready;
  logic [31:0] if_to_mc_PC;
  logic        dec_stall = 1'b0;
  logic        if_to_dec_valid;
  logic [31:0] if_to_dec_inst;
  logic [31:0] if_to_dec_pc;

  always #5 clk_in = ~clk_in;

  icache_fetch #(.IDX_W(6), .RST_PC(32'h0)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
    .redirect_pc(redirect_pc), .mc_to_if_valid(mc_to_if_valid),
    .mc_to_if_ready(mc_to_if_ready), .mc_to_if_inst(mc_to_if_inst),
    .mc_to_if_addr(mc_to_if_addr), .if_to_mc_ready(if_to_mc_ready),
    .if_to_mc_PC(if_to_mc_PC), .dec_stall(dec_stall),
    .if_to_dec_valid(if_to_dec_valid), .if_to_dec_inst(if_to_dec_inst),
    .if_to_dec_pc(if_to_dec_pc)
  );

  typedef struct packed {logic [31:0] pc; logic [31:0] inst;} xfer_t;
  xfer_t exp_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  // reference cache: which address each of the 64 lines currently holds
  logic [31:0] ma [64];
  bit          mv [64];

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0000_0013;
  endfunction

  function automatic bit cached(input logic [31:0] a);
    return mv[a[7:2]] && (ma[a[7:2]] == a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic push_seg(input logic [31:0] start, input int len);
    logic [31:0] a;
    for (int k = 0; k < len; k++) begin
      a = start + 32'(4 * k);
      exp_q.push_back('{pc: a, inst: inst_of(a)});
    end
  endtask

  // monitor: every decoder transfer must match the next expected word and be backed by the cache
  xfer_t got_e;
  always @(negedge clk_in) begin
    if (rst_in && rdy_in && if_to_dec_valid && !dec_stall) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL extra_xfer: got pc %h inst %h, expected no transfer", if_to_dec_pc, if_to_dec_inst);
      end else begin
        got_e = exp_q.pop_front();
        check("dec_pc", if_to_dec_pc, got_e.pc);
        check("dec_inst", if_to_dec_inst, got_e.inst);
        check("dec_line_cached", 32'(cached(if_to_dec_pc)), 32'd1);
      end
    end
  end

  // memory-controller model
  bit          pend = 0, live = 0, stray_arm = 0, wr_pend = 0, first_req = 1, found = 0;
  logic [31:0] pend_addr = 0, stray_addr = 0, wr_addr = 0;
  int          cnt = 0;
  always begin
    @(negedge clk_in);
    if (rst_in && rdy_in) begin
      if (clr_in) begin
        if (pend) begin stray_arm = 1; stray_addr = pend_addr; end
        pend = 0;
      end else begin
        if (mc_to_if_ready && live) begin
          pend = 0; wr_pend = 1; wr_addr = pend_addr;
        end else if (pend && cnt > 0) cnt--;
        if (if_to_mc_ready && mc_to_if_valid) begin
          if (first_req) begin check("first_req_pc", if_to_mc_PC, 32'h0); first_req = 0; end
          check("req_not_cached", 32'(cached(if_to_mc_PC)), 32'd0);
          found = 0;
          foreach (exp_q[i]) if (exp_q[i].pc == if_to_mc_PC) found = 1;
          check("req_expected_pc", 32'(found), 32'd1);
          pend = 1; pend_addr = if_to_mc_PC; cnt = $urandom_range(5, 1);
        end
      end
    end
    @(posedge clk_in);
    if (wr_pend) begin ma[wr_addr[7:2]] = wr_addr; mv[wr_addr[7:2]] = 1; wr_pend = 0; end
    #1;
    live = 0; mc_to_if_ready = 0; mc_to_if_valid = 0;
    mc_to_if_addr = $urandom; mc_to_if_inst = $urandom;
    if (pend && cnt == 0) begin
      live = 1; mc_to_if_ready = 1; mc_to_if_addr = pend_addr; mc_to_if_inst = inst_of(pend_addr);
    end else if (!pend && stray_arm && $urandom_range(3, 0) == 0) begin
      stray_arm = 0; mc_to_if_ready = 1; mc_to_if_addr = stray_addr; mc_to_if_inst = inst_of(stray_addr);
    end else if (!pend && $urandom_range(15, 0) == 0) begin
      mc_to_if_ready = 1; mc_to_if_addr = 32'($urandom_range(255, 0)) << 2;
      mc_to_if_inst = $urandom;
    end
    if (!pend) mc_to_if_valid = ($urandom_range(3, 0) != 0);
  end

  task automatic drain();
    int frz = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (frz > 0) begin rdy_in = 0; frz--; end
      else if ($urandom_range(19, 0) == 0) begin rdy_in = 0; frz = $urandom_range(3, 0); end
      else rdy_in = 1;
      dec_stall = ($urandom_range(3, 0) == 0);
      @(posedge clk_in); #1;
      if (exp_q.size() == 0) break;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain_timeout: got %0d words outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    rdy_in = 1; dec_stall = 1;
  endtask

  task automatic redirect(input logic [31:0] target, input int len);
    clr_in = 1; rdy_in = 1; dec_stall = 1;
    redirect_pc = target | 32'($urandom_range(3, 0));
    push_seg(target, len);
    @(posedge clk_in); #1;
    clr_in = 0;
    drain();
  endtask

  initial begin
    logic [31:0] r;
    foreach (mv[i]) mv[i] = 0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    check("rst_dec_valid", 32'(if_to_dec_valid), 32'd0);
    check("rst_mc_ready", 32'(if_to_mc_ready), 32'd0);
    check("rst_mc_pc", if_to_mc_PC, 32'h0);
    check("rst_dec_inst", if_to_dec_inst, 32'h0);
    check("rst_dec_pc", if_to_dec_pc, 32'h0);
    @(posedge clk_in); #1;
    push_seg(32'h0, 8);
    rst_in = 1;
    drain();
    redirect(32'h0, 2);            // refetch of filled lines: hits only
    redirect(32'h100, 3);          // evicts 0x0..0x8
    redirect(32'h0, 2);            // must miss again
    redirect(32'hFFFF_FFF8, 4);    // pc wraps to 0
    for (int s = 0; s < 30; s++) begin
      case ($urandom_range(4, 0))
        0: r = 32'h0;
        1: r = 32'h100;
        2: r = 32'h8;
        3: r = 32'h200 + (32'($urandom_range(15, 0)) << 2);
        default: r = $urandom & ~32'h3;
      endcase
      redirect(r, $urandom_range(10, 1));
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
